// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first,
// with a registered result, carry-out and signed-overflow flag.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     chunk_sum;
    int                 base;

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    // Carry into the MSB is recovered from the MSB operand and sum bits.
    function automatic logic msb_ovf(input logic x_msb, input logic y_msb,
                                     input logic s_msb, input logic c_out);
        return (x_msb ^ y_msb ^ s_msb) ^ c_out;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        base      = int'(idx_q) * CHUNK;
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_sum = add_chunk(a_chunk, b_chunk, carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d              = chunk_sum[CHUNK];
                idx_d                = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d    = '0;
                    state_d  = DONE;
                    result_d = acc_d;
                    cout_d   = chunk_sum[CHUNK];
                    ovf_d    = msb_ovf(a_chunk[CHUNK-1], b_chunk[CHUNK-1],
                                       chunk_sum[CHUNK-1], chunk_sum[CHUNK]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_chunked_addsub;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              sub;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              cout;
    logic              ovf;

    chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_done_cyc = 0;

    typedef struct {
        logic        s;
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic [15:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic void model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                  input logic ci, output logic [15:0] r,
                                  output logic co, output logic ov);
        int ux, uy, sx, sy, us, ss;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            us = ux - uy;
            ss = sx - sy;
            co = (ux >= uy);
        end else begin
            us = ux + uy + int'(ci);
            ss = sx + sy + int'(ci);
            co = (us > 65535);
        end
        r  = us[15:0];
        ov = (ss > 32767) || (ss < -32768);
    endfunction

    // Called at a negedge; returns at the negedge of the IDLE cycle after done.
    task automatic run_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic noisy,
                          output logic [15:0] r, output logic co, output logic ov);
        int  bcnt;
        int  lat;
        logic seen;
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        cin   = ci;
        @(posedge clk);
        #1;
        start = noisy;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        bcnt  = 0;
        lat   = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) bcnt++;
                if (noisy) begin
                    a   = 16'($urandom);
                    b   = 16'($urandom);
                    sub = 1'($urandom);
                    cin = 1'($urandom);
                end
            end
        end
        chk("done_seen", seen, 1);
        chk("done_latency", lat, N + 1);
        chk("busy_cycles", bcnt, N);
        chk("busy_low_in_done", busy, 0);
        r  = result;
        co = cout;
        ov = ovf;
        last_done_cyc = cyc;
        start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_low_in_idle", busy, 0);
    endtask

    task automatic check_res(input string name, input logic [15:0] r, input logic co,
                             input logic ov, input logic [15:0] er, input logic eco,
                             input logic eov);
        chk({name, "_result"}, r, er);
        chk({name, "_cout"}, co, eco);
        chk({name, "_ovf"}, ov, eov);
    endtask

    initial begin
        logic [15:0] r, er, held;
        logic        co, ov, eco, eov;
        logic        s, ci, nz;
        logic [15:0] x, y;
        int          d1, dcount;

        tbl[0]  = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, done, result, cout, ovf}, 0);
        reset = 1'b0;

        // Directed table; the first start is right after reset release.
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].ci, 1'b0, r, co, ov);
            check_res($sformatf("vec%0d", i), r, co, ov, tbl[i].r, tbl[i].co, tbl[i].ov);
        end

        // Outputs hold while idle with inputs wiggling and start low.
        held = result;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
        end
        chk("hold_result", result, held);
        chk("hold_no_done", done, 0);

        // Start and operand changes during RUN/DONE are ignored.
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, r, co, ov);
        check_res("noisy", r, co, ov, 16'h5555, 1'b0, 1'b0);

        // Back-to-back: second done exactly N+2 cycles after the first.
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0, r, co, ov);
        check_res("b2b_first", r, co, ov, 16'h7FFF, 1'b1, 1'b1);
        d1 = last_done_cyc;
        run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, r, co, ov);
        check_res("b2b_second", r, co, ov, 16'h1000, 1'b0, 1'b0);
        chk("b2b_spacing", last_done_cyc - d1, N + 2);

        // Reset on the second RUN cycle aborts without a done pulse.
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h00FF;
        b     = 16'h0F0F;
        cin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_run2", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cleared", {busy, done, result, cout, ovf}, 0);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, r, co, ov);
        check_res("after_abort", r, co, ov, 16'h0002, 1'b0, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            s  = 1'($urandom);
            ci = 1'($urandom);
            nz = 1'($urandom);
            x  = 16'($urandom);
            y  = 16'($urandom);
            if (i % 8 == 0) x = 16'h8000;
            if (i % 8 == 4) y = 16'hFFFF;
            model(s, x, y, ci, er, eco, eov);
            run_op(s, x, y, ci, nz, r, co, ov);
            check_res($sformatf("rand%0d", i), r, co, ov, er, eco, eov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chunked_addsub.md
CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, N = WIDTH/CHUNK.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL provide port sub  input  1  mode: 0 = add, 1 = subtract (a - b).
REQ-007 SHALL provide port a  input  WIDTH  first operand.
REQ-008 SHALL provide port b  input  WIDTH  second operand.
REQ-009 SHALL provide port cin  input  1  carry-in; used in add mode only.
REQ-010 SHALL provide port busy  output  1  high while chunks are being computed.
REQ-011 SHALL provide port done  output  1  one-cycle pulse: result valid and newly updated.
REQ-012 SHALL provide port result  output  WIDTH  registered sum/difference.
REQ-013 SHALL provide port cout  output  1  final carry-out (subtract: 1 = no borrow).
REQ-014 SHALL provide port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE with start=1 at an edge SHALL latch a, b, sub and the effective carry (sub ? 1 : cin), clear the chunk index to 0, and go to RUN.
REQ-017 In subtract mode, the latched b SHALL be bit-inverted, so that a + ~b + 1 is computed.
REQ-018 At each RUN edge, chunk idx SHALL be added: bits [idx*CHUNK +: CHUNK] of the latched operands plus the running carry; the chunk sum is stored in an internal accumulator, the carry is updated, and idx increments.
REQ-019 At the RUN edge that processes idx = N-1, the FSM SHALL go to DONE and load result, cout and ovf from the accumulator and final carries.
REQ-020 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-022 busy SHALL be 1 exactly in RUN and done SHALL be 1 exactly in DONE; both SHALL be registered outputs.
REQ-023 Latency: done SHALL be high in the cycle following the Nth rising edge after the accepting edge; busy SHALL be high for N cycles.
REQ-024 start SHALL be ignored in RUN and DONE; changes on a, b, sub and cin after acceptance SHALL NOT affect the operation in progress.
REQ-025 result, cout and ovf SHALL change only on entry to DONE and SHALL hold their values until the next completion or reset.
REQ-026 Accepting start again from IDLE in the cycle after DONE SHALL be supported, giving a throughput of one operation per N+2 cycles.
REQ-027 With CHUNK = WIDTH (N = 1), the block SHALL still pass through RUN for one cycle before DONE.

Reset
REQ-028 With reset=1 at an edge, the FSM SHALL enter IDLE; busy, done, result, cout, ovf, idx, the accumulator and the carry SHALL all be cleared to 0.
REQ-029 reset SHALL take priority over start and over any operation in progress; an aborted operation SHALL produce no done pulse.
REQ-030 After reset deasserts, start SHALL be accepted at the first edge.

Verification (WIDTH=16, CHUNK=4)
REQ-031 add 0x1234 + 0x4321, cin=0 -> result 0x5555, cout=0, ovf=0; busy high for 4 cycles, then done for 1 cycle.
REQ-032 add 0xFFFF + 0x0001, cin=0 -> 0x0000, cout=1, ovf=0; add 0x7FFF + 0x0000, cin=1 -> 0x8000, cout=0, ovf=1.
REQ-033 sub 0x0005 - 0x0007 (cin=0) -> 0xFFFE, cout=0, ovf=0; sub 0x8000 - 0x0001 -> 0x7FFF, cout=1, ovf=1.
REQ-034 Mid-RUN: drive start=1 with new operands and toggle sub -> no effect; the original result appears at the original done time.
REQ-035 Reset asserted on the 2nd RUN cycle -> IDLE next cycle, all outputs 0, no done; a subsequent 0x0001 + 0x0001 -> 0x0002.
REQ-036 Back-to-back: a new start in the cycle after done -> second done exactly 6 cycles after the first; each result correct.
